// File: rtl/ps2_cursor_controller.sv
// PS/2 keyboard receiver and key decoder. It oversamples the PS/2 pins on the system clock
// and converts keystrokes into a cursor position and a square colour for the VGA controller.
module ps2_cursor_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned STEP           = 32
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic [7:0] oXRedCounter,
    output logic [7:0] oYRedCounter,
    output logic [2:0] oColorCuadro,
    output logic [7:0] oScanCode,
    output logic       oScanValid,
    output logic       oFrameError
);

    localparam int unsigned CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  STEP_B  = 8'(STEP);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    rx_state_t     state_q;
    logic          clk_s1_q, clk_s2_q, clk_s3_q;
    logic          dat_s1_q, dat_s2_q;
    logic [7:0]    shift_q;
    logic [2:0]    bitcnt_q;
    logic          parity_q;
    logic [CW-1:0] tmo_q;
    logic [7:0]    scan_code_q;
    logic          scan_valid_q;
    logic          frame_err_q;
    logic          fall;

    logic [7:0] x_q, x_d, y_q, y_d;
    logic [2:0] col_q, col_d;
    logic       brk_q, brk_d, ext_q, ext_d;

    assign fall = clk_s3_q & ~clk_s2_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_s3_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            state_q      <= IDLE;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= iPS2_CLK;
            clk_s2_q     <= clk_s1_q;
            clk_s3_q     <= clk_s2_q;
            dat_s1_q     <= iPS2_DATA;
            dat_s2_q     <= dat_s1_q;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (state_q == IDLE) begin
                tmo_q <= '0;
                // A high bit seen while idle is a framing slip and is dropped silently.
                if (fall && !dat_s2_q) begin
                    state_q  <= DATA;
                    bitcnt_q <= '0;
                end
            end else if (fall) begin
                tmo_q <= '0;
                unique case (state_q)
                    DATA: begin
                        shift_q <= {dat_s2_q, shift_q[7:1]};
                        if (bitcnt_q == 3'd7) state_q <= PARITY;
                        else                  bitcnt_q <= bitcnt_q + 3'd1;
                    end
                    PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        if (dat_s2_q && ((^shift_q) ^ parity_q)) begin
                            scan_code_q  <= shift_q;
                            scan_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (tmo_q == TO_LAST) begin
                tmo_q   <= '0;
                state_q <= IDLE;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        col_d = col_q;
        brk_d = brk_q;
        ext_d = ext_q;
        if (scan_valid_q) begin
            if (scan_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (scan_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                ext_d = 1'b0;
                if (scan_code_q == 8'h1D || (ext_q && scan_code_q == 8'h75))
                    y_d = y_q - STEP_B;
                else if (scan_code_q == 8'h1B || (ext_q && scan_code_q == 8'h72))
                    y_d = y_q + STEP_B;
                else if (scan_code_q == 8'h1C || (ext_q && scan_code_q == 8'h6B))
                    x_d = x_q - STEP_B;
                else if (scan_code_q == 8'h23 || (ext_q && scan_code_q == 8'h74))
                    x_d = x_q + STEP_B;
                else if (scan_code_q == 8'h29)
                    // Black is the frame colour, so the cycle skips 3'b000.
                    col_d = (col_q == 3'b111) ? 3'b001 : col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            x_q   <= '0;
            y_q   <= '0;
            col_q <= 3'b001;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            col_q <= col_d;
            brk_q <= brk_d;
            ext_q <= ext_d;
        end
    end

    assign oXRedCounter = x_q;
    assign oYRedCounter = y_q;
    assign oColorCuadro = col_q;
    assign oScanCode    = scan_code_q;
    assign oScanValid   = scan_valid_q;
    assign oFrameError  = frame_err_q;

endmodule

// File: doc/ps2_cursor_controller.md
# ps2_cursor_controller

Receives PS/2 keyboard frames on the system clock domain and turns keystrokes into the cursor position and square colour that the VGA controller consumes. It sits directly upstream of the VGA controller: its position and colour outputs drive the VGA controller's X/Y cursor inputs and square-colour input. PS/2 clock and data are treated as asynchronous inputs and oversampled. The block never clocks logic on the PS/2 clock.

## Interface
- TIMEOUT_CYCLES, default 50000: Clock cycles allowed between PS/2 clock falling edges inside a frame before the frame is abandoned.
- STEP, default 32: cursor increment/decrement per keypress, in pixels.
- Clock  in  1  system clock (25 MHz pixel clock).
- Reset  in  1  reset, asynchronous, active-high.
- iPS2_CLK  in  1  raw PS/2 clock pin.
- iPS2_DATA  in  1  raw PS/2 data pin.
- oXRedCounter  out  8  cursor X offset inside the 256x256 image.
- oYRedCounter  out  8  cursor Y offset.
- oColorCuadro  out  3  cursor square colour {R,G,B}.
- oScanCode  out  8  last correctly received byte.
- oScanValid  out  1  one-cycle pulse when oScanCode is updated.
- oFrameError  out  1  one-cycle pulse on a parity or stop-bit error.

## Operation
**Input synchronisation**
- Each pin passes through 2 flops (s1, s2). A third flop s3 holds the previous s2 of the clock line.
- Falling edge (fall) = s3 & ~s2. Data is taken from s2 of the data line at the same Clock edge.

**Receive FSM** (states IDLE, DATA, PARITY, STOP):
- IDLE: on fall with data 0 (start bit), go to DATA with bit count 0. On fall with data 1, stay in IDLE; this is a framing slip and is silently ignored.
- DATA: on each fall, shift the data bit in LSB-first. After the 8th bit, go to PARITY.
- PARITY: on fall, capture the parity bit and go to STOP.
- STOP: on fall, check two conditions: stop bit is 1, and XOR of the 8 data bits plus the parity bit is 1 (odd parity).
  - Both pass: load oScanCode and pulse oScanValid.
  - Either fails: pulse oFrameError; oScanCode is unchanged.
  - In both cases, return to IDLE.
- Timeout: a counter clears on every fall and increments each Clock while not in IDLE. When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, the partial byte is discarded, and no pulse is issued.

**Key decoder** (acts only on oScanValid; flags brk and ext):
- 0xF0: set brk.
- 0xE0: set ext.
- Any other code with brk=1: release event. Clear brk and ext; no action.
- Any other code with brk=0: act on the code per the list below, then clear ext.
  - Up: 0x1D (W), or 0x75 with ext. Y <= Y - STEP.
  - Down: 0x1B (S), or 0x72 with ext. Y <= Y + STEP.
  - Left: 0x1C (A), or 0x6B with ext. X <= X - STEP.
  - Right: 0x23 (D), or 0x74 with ext. X <= X + STEP.
  - Space 0x29: colour +1. Colour 3'b111 goes to 3'b001; 3'b000 (black, frame colour) is never produced.
  - Any other code: no change.
- X/Y arithmetic is 8-bit modulo 256 and wraps: 0 - 32 = 224, 224 + 32 = 0.

## Timing
- Reset values: oXRedCounter=0, oYRedCounter=0, oColorCuadro=3'b001, oScanCode=0, oScanValid=0, oFrameError=0. FSM is in IDLE; brk=0, ext=0; timeout counter=0; sync flops=1 (idle bus).
- Let k be the Clock edge that first samples the pin low. s2 goes low at k+1. fall is true between k+1 and k+2, and the FSM acts at edge k+2.
- Stop-bit fall: oScanValid or oFrameError is high for exactly the one cycle after edge k+2.
- Cursor and colour registers update at edge k+3, which is the edge that samples oScanValid. Outputs are registered and stable between updates.
- Reset asserted mid-frame aborts the frame immediately and clears all state. The first fall after release must be a start bit to begin a new frame.
- Codes arrive at least about 1 ms apart, so a decode and the next oScanValid never coincide.

## Test plan
- **Reset**: assert Reset while in DATA -> all outputs at reset values, FSM in IDLE; a following valid frame 0x23 -> oScanValid pulse, oXRedCounter=32.
- **Make/break**: send frames 0x1D, F0, 1D from reset -> oYRedCounter=224 after the first byte, unchanged after F0 1D; oScanCode=0x1D at the end.
- **Extended keys**: send E0 74 twice, then E0 F0 74 -> oXRedCounter=64 (the release does not move it).
- **Colour wrap**: press space 7 times (each followed by F0 29) -> colour sequence 2,3,4,5,6,7,1.
- **Parity error**: send 0x23 with even parity -> oFrameError one-cycle pulse, no oScanValid, oXRedCounter unchanged.
- **Timeout**: stop the PS/2 clock after 4 data bits for more than TIMEOUT_CYCLES (TIMEOUT_CYCLES=100 in sim), then send a full frame 0x1C -> only the new frame is accepted, oXRedCounter=224.
